// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} kp_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } cand_t;

    localparam cand_t CAND_NONE = '{valid: 1'b0, code: 4'h0};

    // Single pressed key -> its code; none or several -> NONE (code forced to 0
    // so that equality between NONE candidates is exact).
    function automatic cand_t classify(input logic [NUM_COLS*NUM_ROWS-1:0] snap);
        cand_t c;
        int    n;
        c = CAND_NONE;
        n = 0;
        for (int i = 0; i < NUM_COLS*NUM_ROWS; i++) begin
            if (snap[i]) begin
                n = n + 1;
                c.code = 4'(i);
            end
        end
        if (n == 1) c.valid = 1'b1;
        else        c.code  = 4'h0;
        return c;
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Scan-count debounce with n-key lockout; owns the key/key_valid/key_held outputs.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_done,
    input  logic       cand_valid,
    input  logic [3:0] cand_code,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DC_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE_SCANS);

    cand_t             cand;
    cand_t             prev_q, prev_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    kp_state_e         state_q, state_d;
    logic [3:0]        key_q, key_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;

    assign cand = '{valid: cand_valid, code: cand_code};

    always_comb begin
        prev_d  = prev_q;
        dc_d    = dc_q;
        state_d = state_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (scan_done) begin
            prev_d = cand;
            if (cand == prev_q) dc_d = (dc_q == DC_MAX) ? DC_MAX : dc_q + DC_W'(1);
            else                dc_d = DC_W'(1);
            // A different stable key while PRESSED is ignored: a new event needs a release first.
            if (dc_d == DC_MAX) begin
                case (state_q)
                    RELEASED: if (cand.valid) begin
                        state_d = PRESSED;
                        key_d   = cand.code;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end
                    PRESSED: if (!cand.valid) begin
                        state_d = RELEASED;
                        held_d  = 1'b0;
                    end
                    default: state_d = RELEASED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= CAND_NONE;
            dc_q    <= '0;
            state_q <= RELEASED;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            dc_q    <= dc_d;
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, per-scan snapshot and classification.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]                      row_s1_q, row_s2_q;
    logic [DIV_W-1:0]                div_q, div_d;
    logic [1:0]                      ci_q, ci_d;
    logic [NUM_COLS*NUM_ROWS-1:0]    snap_q, snap_d;
    logic                            done_q, done_d;
    logic                            last;
    cand_t                           cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    assign last = (div_q == DIV_LAST);

    // Rows are sampled on the final dwell cycle so the synchronizer and the
    // keypad wiring have settled after the column switch.
    always_comb begin
        div_d  = last ? '0 : div_q + DIV_W'(1);
        ci_d   = last ? ci_q + 2'd1 : ci_q;
        snap_d = snap_q;
        if (last) snap_d[{ci_q, 2'b00} +: 4] = ~row_s2_q;
        done_d = last && (ci_q == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            ci_q   <= 2'd0;
            snap_q <= '0;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            ci_q   <= ci_d;
            snap_q <= snap_d;
            done_q <= done_d;
        end
    end

    assign col  = ~(4'b0001 << ci_q);
    assign cand = classify(snap_q);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_done  (done_q),
        .cand_valid (cand.valid),
        .cand_code  (cand.code),
        .key        (key),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );
endmodule
